vending_controller: RTL
=======================

Name: vending_controller

Overview:
- Sequential stage directly downstream of the item encoder; consumes its 5-bit one-hot price-class code for the selected item.
- Latches a selection, accumulates inserted coins and dispenses once the price class is paid.
- Returns change, and refunds on cancel or on inactivity timeout.
- Feeds the dispense mechanism and the change/refund unit.

Parameters:
- PRICE0, 10, price of class item[0] in 5-unit coin credits (all prices in credits)
- PRICE1, 15, price of class item[1]
- PRICE2, 20, price of class item[2]
- PRICE3, 25, price of class item[3]
- PRICE4, 30, price of class item[4]
- TIMEOUT, 1000, clk cycles without a coin in COLLECT before auto-refund
- Prices must be 1..255.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- item  in  5  one-hot price class from item encoder
- item_valid  in  1  one-cycle strobe: item holds a new selection
- coin  in  2  00 none, 01 = 5 units (1 credit), 10 = 10 units (2), 11 = 20 units (4); sampled every cycle
- cancel  in  1  level; refund request
- busy  out  1  high whenever state != IDLE
- sel_err  out  1  one-cycle pulse: item_valid with zero or multi-hot item
- coin_reject  out  1  one-cycle pulse: coin not accepted
- dispense  out  1  one-cycle pulse: release the item
- class_out  out  5  latched class; valid while busy
- balance  out  8  accumulated credits
- change_valid  out  1  one-cycle pulse qualifying change_amt
- change_amt  out  8  credits to return; held until the next change_valid

Behaviour:
- Reset: async assert, forces state IDLE and clears all registers. All outputs are 0 while rst is high and after release.
- States:
  - IDLE
    - item_valid with exactly one bit set: latch class_out, load price, balance = 0, enter COLLECT next cycle.
    - Otherwise item_valid: pulse sel_err next cycle, stay IDLE.
    - Coins in IDLE: coin_reject pulse next cycle, balance unchanged.
  - COLLECT
    - Nonzero coin: balance += credit on the next edge, and the timeout counter reloads.
    - If balance + credit > 255: coin rejected, coin_reject pulses, balance unchanged.
    - item_valid is ignored; no sel_err.
    - Priority, highest first: cancel, then coin, then timeout.
    - cancel high: enter REFUND; a coin in the same cycle is rejected.
    - Timeout counter reaches TIMEOUT-1 with no coin: enter REFUND.
    - Registered balance >= price: enter DISPENSE. This check happens the cycle after the paying coin lands in balance.
  - DISPENSE
    - One cycle; dispense = 1. Next state CHANGE.
    - Coins this cycle are rejected; cancel is ignored.
  - CHANGE
    - One cycle; change_valid = 1, change_amt = balance - price (0 allowed, pulse still issued).
    - balance cleared; next state IDLE.
  - REFUND
    - One cycle; change_valid = 1, change_amt = balance (may be 0); balance cleared; next state IDLE. No dispense.
    - Coins this cycle are rejected.
- Latency, paying coin at edge N: balance updates N+1, dispense N+2, change_valid N+3, busy low N+4.
- Outputs are registered; pulses are exactly one cycle wide.
- Arithmetic: 8-bit unsigned; subtraction only when balance >= price.
- Mid-operation reset: everything aborts immediately; no dispense or change is issued and balance is lost.

Test Plan:
- Reset release, then item=00100 strobed → busy=1, class_out=00100. Coins 11,11,11,11,11 (20 credits) → dispense on the 2nd edge after the last coin, then change_valid with change_amt=0.
- item=00001; coins 11,11,11 (12 credits) → dispense, then change_amt=2 (PRICE0=10).
- item=10000; coin 10 then cancel=1 → REFUND: change_valid with change_amt=2, dispense never asserted, busy low after.
- item=00000 and item=00011 strobes in IDLE → sel_err pulse each time, busy stays 0. Coin in IDLE → coin_reject.
- TIMEOUT=8: item=01000, one coin 01, then idle → after 8 cycles REFUND with change_amt=1. A coin at cycle 7 reloads the counter.
- Edge cases:
  - cancel and coin in the same cycle → coin_reject plus refund of the prior balance only.
  - Balance 254 plus coin 11 → coin_reject.
  - rst mid-COLLECT → all outputs 0 asynchronously, no change pulse.

Source files
------------

// File: rtl/vending_controller.sv
// Vending controller: latches a one-hot price class from the item encoder,
// accumulates coin credits, dispenses once the price is paid and returns
// change. Cancel or an inactivity timeout refunds the balance instead.
// All outputs come straight from registers.
module vending_controller #(
  parameter int PRICE0  = 10,
  parameter int PRICE1  = 15,
  parameter int PRICE2  = 20,
  parameter int PRICE3  = 25,
  parameter int PRICE4  = 30,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] item,
  input  logic       item_valid,
  input  logic [1:0] coin,
  input  logic       cancel,
  output logic       busy,
  output logic       sel_err,
  output logic       coin_reject,
  output logic       dispense,
  output logic [4:0] class_out,
  output logic [7:0] balance,
  output logic       change_valid,
  output logic [7:0] change_amt
);

  // Inactivity counter only needs to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE,
    S_REFUND
  } state_t;

  // Registered state and outputs
  state_t          r_state;
  logic [4:0]      r_class;
  logic [7:0]      r_price;
  logic [7:0]      r_balance;
  logic [TW-1:0]   r_tcnt;
  logic            r_sel_err;
  logic            r_coin_reject;
  logic            r_dispense;
  logic            r_change_valid;
  logic [7:0]      r_change_amt;

  // Next-state values
  state_t          w_state;
  logic [4:0]      w_class;
  logic [7:0]      w_price;
  logic [7:0]      w_balance;
  logic [TW-1:0]   w_tcnt;
  logic            w_sel_err;
  logic            w_coin_reject;
  logic            w_dispense;
  logic            w_change_valid;
  logic [7:0]      w_change_amt;

  // Decoded inputs
  logic [2:0]      w_credit;
  logic [8:0]      w_sum;
  logic            w_coin_present;
  logic            w_coin_fits;
  logic            w_item_onehot;
  logic [7:0]      w_item_price;

  // Coin decoding, one-hot check and price lookup for the presented item.
  always_comb begin
    w_credit = 3'd0;
    case (coin)
      2'b01:   w_credit = 3'd1;
      2'b10:   w_credit = 3'd2;
      2'b11:   w_credit = 3'd4;
      default: w_credit = 3'd0;
    endcase

    w_coin_present = (coin != 2'b00);
    // Ninth bit of the sum flags a coin that would overflow the 8-bit balance.
    w_sum          = {1'b0, r_balance} + {6'd0, w_credit};
    w_coin_fits    = ~w_sum[8];

    w_item_onehot  = (item != 5'd0) && ((item & (item - 5'd1)) == 5'd0);

    w_item_price = 8'd0;
    case (item)
      5'b00001: w_item_price = 8'(PRICE0);
      5'b00010: w_item_price = 8'(PRICE1);
      5'b00100: w_item_price = 8'(PRICE2);
      5'b01000: w_item_price = 8'(PRICE3);
      5'b10000: w_item_price = 8'(PRICE4);
      default:  w_item_price = 8'd0;
    endcase
  end

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state        = r_state;
    w_class        = r_class;
    w_price        = r_price;
    w_balance      = r_balance;
    w_tcnt         = r_tcnt;
    w_sel_err      = 1'b0;
    w_coin_reject  = 1'b0;
    w_dispense     = 1'b0;
    w_change_valid = 1'b0;
    w_change_amt   = r_change_amt;

    case (r_state)
      S_IDLE: begin
        // No transaction open: any coin goes straight back.
        w_coin_reject = w_coin_present;
        if (item_valid) begin
          if (w_item_onehot) begin
            w_state   = S_COLLECT;
            w_class   = item;
            w_price   = w_item_price;
            w_balance = 8'd0;
            w_tcnt    = '0;
          end else begin
            w_sel_err = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (cancel) begin
          // Cancel wins over a simultaneous coin; only the prior balance returns.
          w_state        = S_REFUND;
          w_coin_reject  = w_coin_present;
          w_change_valid = 1'b1;
          w_change_amt   = r_balance;
          w_balance      = 8'd0;
        end else if (r_balance >= r_price) begin
          // Paid: the check uses the registered balance, one cycle after the coin.
          w_state       = S_DISPENSE;
          w_dispense    = 1'b1;
          w_coin_reject = w_coin_present;
        end else if (w_coin_present && w_coin_fits) begin
          w_balance = w_sum[7:0];
          w_tcnt    = '0;
        end else begin
          // No accepted coin this cycle: an overflowing coin is bounced and the
          // inactivity timer keeps running.
          w_coin_reject = w_coin_present;
          if (r_tcnt == TCNT_LAST) begin
            w_state        = S_REFUND;
            w_change_valid = 1'b1;
            w_change_amt   = r_balance;
            w_balance      = 8'd0;
          end else begin
            w_tcnt = r_tcnt + TW'(1);
          end
        end
      end

      S_DISPENSE: begin
        // Cancel is ignored once the item is on its way.
        w_state        = S_CHANGE;
        w_coin_reject  = w_coin_present;
        w_change_valid = 1'b1;
        w_change_amt   = r_balance - r_price;
        w_balance      = 8'd0;
      end

      S_CHANGE: begin
        w_state       = S_IDLE;
        w_coin_reject = w_coin_present;
      end

      S_REFUND: begin
        w_state       = S_IDLE;
        w_coin_reject = w_coin_present;
      end

      default: begin
        w_state   = S_IDLE;
        w_balance = 8'd0;
      end
    endcase
  end

  // State and output registers; async reset aborts any transaction silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_class        <= 5'd0;
      r_price        <= 8'd0;
      r_balance      <= 8'd0;
      r_tcnt         <= '0;
      r_sel_err      <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_dispense     <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_amt   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, independent of statement order.
      r_state        <= w_state;
      r_class        <= w_class;
      r_price        <= w_price;
      r_balance      <= w_balance;
      r_tcnt         <= w_tcnt;
      r_sel_err      <= w_sel_err;
      r_coin_reject  <= w_coin_reject;
      r_dispense     <= w_dispense;
      r_change_valid <= w_change_valid;
      r_change_amt   <= w_change_amt;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign sel_err      = r_sel_err;
  assign coin_reject  = r_coin_reject;
  assign dispense     = r_dispense;
  assign class_out    = r_class;
  assign balance      = r_balance;
  assign change_valid = r_change_valid;
  assign change_amt   = r_change_amt;

endmodule
